bcd_time_core: RTL

Time-of-day engine that feeds the APB alarm block. It keeps the running BCD clock that the alarm comparator reads back as the "now" time. It divides `pclk_i` down to a one-second tick and counts seconds, BCD minutes and BCD hours (00:00–23:59). It also loads a start time from the init register fields, and rejects invalid BCD.

---
 rtl/alarm_pkg.sv | 28 ++
 rtl/bcd_digit_counter.sv | 40 ++++
 rtl/bcd_time_core.sv | 108 ++++++++++
 3 files changed

// File: rtl/alarm_pkg.sv
// Shared types and helpers for the alarm time path.
// bcd_time_t matches the 16-bit time_init/time_now layout, with the hour in the upper byte.
package alarm_pkg;

  typedef struct packed {
    logic [3:0] hourdec;
    logic [3:0] hourone;
    logic [3:0] mindec;
    logic [3:0] minone;
  } bcd_time_t;

  localparam int SEC_MAX       = 59;
  localparam int MINDEC_MAX    = 5;
  localparam int HOURDEC_MAX   = 2;
  localparam int HOUR_WRAP_ONE = 3;

  // A valid time lies in 00:00..23:59 and every digit is a legal BCD digit.
  function automatic logic bcd_time_valid(input bcd_time_t t);
    logic ok;
    ok = (t.hourdec <= 4'(HOURDEC_MAX)) &&
         (t.hourone <= 4'd9) &&
         !((t.hourdec == 4'(HOURDEC_MAX)) && (t.hourone > 4'(HOUR_WRAP_ONE))) &&
         (t.mindec <= 4'(MINDEC_MAX)) &&
         (t.minone <= 4'd9);
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit: counts 0..MAX with a carry out on wrap.
// Priority is load, then clear, then increment.
module bcd_digit_counter #(
  parameter int MAX = 9
) (
  input  logic       pclk_i,
  input  logic       presetn_i,
  input  logic       inc_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       clr_i,
  output logic [3:0] val_o,
  output logic       carry_o
);

  localparam logic [3:0] MAX_V = 4'(MAX);

  logic [3:0] val_q, val_d;

  always_comb begin
    val_d = val_q;
    if (load_i)
      val_d = load_val_i;
    else if (clr_i)
      val_d = '0;
    else if (inc_i)
      val_d = (val_q == MAX_V) ? 4'd0 : val_q + 4'd1;
  end

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i)
      val_q <= '0;
    else
      val_q <= val_d;
  end

  assign val_o   = val_q;
  assign carry_o = inc_i && !load_i && !clr_i && (val_q == MAX_V);

endmodule

// File: rtl/bcd_time_core.sv
// Time-of-day engine: prescaler to a one-second tick, binary seconds, BCD hh:mm.
// Supplies the running "now" time to the alarm comparator; loads are validated.
module bcd_time_core
  import alarm_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic       pclk_i,
  input  logic       presetn_i,
  input  logic       run_i,
  input  logic       load_i,
  input  logic [3:0] hourdec_init_i,
  input  logic [3:0] hourone_init_i,
  input  logic [3:0] mindec_init_i,
  input  logic [3:0] minone_init_i,
  output logic [3:0] hourdec_o,
  output logic [3:0] hourone_o,
  output logic [3:0] mindec_o,
  output logic [3:0] minone_o,
  output logic [5:0] sec_o,
  output logic       sec_tick_o,
  output logic       min_tick_o,
  output logic       day_tick_o,
  output logic       load_err_o
);

  localparam int          PW     = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRE_TC = PW'(TICKS_PER_SEC - 1);

  bcd_time_t init_t;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0] sec_q, sec_d;
  logic sec_tick_q, min_tick_q, day_tick_q, load_err_q;
  logic load_ok, load_bad, pre_tc, sec_adv, min_inc;
  logic minone_carry, mindec_carry, hourone_carry, hourdec_carry;
  logic hour_wrap, hourone_inc;

  assign init_t   = {hourdec_init_i, hourone_init_i, mindec_init_i, minone_init_i};
  assign load_ok  = load_i && bcd_time_valid(init_t);
  assign load_bad = load_i && !bcd_time_valid(init_t);
  assign pre_tc   = run_i && (presc_q == PRE_TC);
  // A valid load swallows a coincident second boundary.
  assign sec_adv  = pre_tc && !load_ok;
  assign min_inc  = sec_adv && (sec_q == 6'(SEC_MAX));

  always_comb begin
    presc_d = presc_q;
    sec_d   = sec_q;
    if (load_ok)
      presc_d = '0;
    else if (run_i)
      presc_d = pre_tc ? '0 : presc_q + 1'b1;
    if (load_ok)
      sec_d = '0;
    else if (sec_adv)
      sec_d = (sec_q == 6'(SEC_MAX)) ? 6'd0 : sec_q + 6'd1;
  end

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      presc_q    <= '0;
      sec_q      <= '0;
      sec_tick_q <= 1'b0;
      min_tick_q <= 1'b0;
      day_tick_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      sec_q      <= sec_d;
      sec_tick_q <= sec_adv;
      min_tick_q <= min_inc;
      day_tick_q <= hour_wrap;
      load_err_q <= load_bad;
    end
  end

  bcd_digit_counter #(.MAX(9)) u_minone (
    .pclk_i, .presetn_i, .inc_i(min_inc), .load_i(load_ok), .load_val_i(minone_init_i),
    .clr_i(1'b0), .val_o(minone_o), .carry_o(minone_carry)
  );

  bcd_digit_counter #(.MAX(MINDEC_MAX)) u_mindec (
    .pclk_i, .presetn_i, .inc_i(minone_carry), .load_i(load_ok), .load_val_i(mindec_init_i),
    .clr_i(1'b0), .val_o(mindec_o), .carry_o(mindec_carry)
  );

  // 23 -> 00 is not a natural digit wrap, so both hour digits are cleared together.
  assign hour_wrap   = mindec_carry && (hourdec_o == 4'(HOURDEC_MAX)) &&
                       (hourone_o == 4'(HOUR_WRAP_ONE));
  assign hourone_inc = mindec_carry && !hour_wrap;

  bcd_digit_counter #(.MAX(9)) u_hourone (
    .pclk_i, .presetn_i, .inc_i(hourone_inc), .load_i(load_ok), .load_val_i(hourone_init_i),
    .clr_i(hour_wrap), .val_o(hourone_o), .carry_o(hourone_carry)
  );

  bcd_digit_counter #(.MAX(HOURDEC_MAX)) u_hourdec (
    .pclk_i, .presetn_i, .inc_i(hourone_carry), .load_i(load_ok), .load_val_i(hourdec_init_i),
    .clr_i(hour_wrap), .val_o(hourdec_o), .carry_o(hourdec_carry)
  );

  assign sec_o      = sec_q;
  assign sec_tick_o = sec_tick_q;
  assign min_tick_o = min_tick_q;
  assign day_tick_o = day_tick_q;
  assign load_err_o = load_err_q;

endmodule
